// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS definitions for the ID-stage control slice:
//                next-PC select codes, opcode/funct constants, the ID event
//                type and instruction classification helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    // Next-PC select codes consumed by the fetch stage
    localparam logic [2:0] PCSRC_SEQ    = 3'd0;
    localparam logic [2:0] PCSRC_BRANCH = 3'd1;
    localparam logic [2:0] PCSRC_JUMP   = 3'd2;
    localparam logic [2:0] PCSRC_REG    = 3'd3;
    localparam logic [2:0] PCSRC_IRQ    = 3'd4;
    localparam logic [2:0] PCSRC_EXC    = 3'd5;

    localparam logic [31:0] NOP = 32'h0;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // The single event that acts in ID this cycle, highest priority first
    typedef enum logic [2:0] {
        EV_SEQ      = 3'd0,
        EV_BRANCH   = 3'd1,
        EV_LOAD_USE = 3'd2,
        EV_EXC      = 3'd3,
        EV_IRQ      = 3'd4,
        EV_JUMP     = 3'd5
    } id_event_e;

    function automatic logic is_rtype_funct(input logic [5:0] funct);
        case (funct)
            FN_SLL, FN_SRL, FN_SRA, FN_JR, FN_JALR,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
            FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: is_rtype_funct = 1'b1;
            default:                                        is_rtype_funct = 1'b0;
        endcase
    endfunction

    // Only bltz is supported in the REGIMM space, so rt must be zero there.
    function automatic logic is_defined(input logic [31:0] instr);
        case (instr[31:26])
            OP_RTYPE:  is_defined = is_rtype_funct(instr[5:0]);
            OP_REGIMM: is_defined = (instr[20:16] == 5'd0);
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI,
            OP_LUI, OP_LW, OP_SW: is_defined = 1'b1;
            default:              is_defined = 1'b0;
        endcase
    endfunction

    // rs is a source for every supported instruction except shifts-by-shamt,
    // lui and the absolute jumps (whose rs field is part of the target).
    function automatic logic reads_rs(input logic [31:0] instr);
        logic r;
        r = is_defined(instr);
        case (instr[31:26])
            OP_RTYPE: if (instr[5:0] == FN_SLL || instr[5:0] == FN_SRL ||
                          instr[5:0] == FN_SRA) r = 1'b0;
            OP_J, OP_JAL, OP_LUI: r = 1'b0;
            default: ;
        endcase
        reads_rs = r;
    endfunction

    // rt is a source for R-type ALU/shift ops, stores and two-register branches.
    function automatic logic reads_rt(input logic [31:0] instr);
        case (instr[31:26])
            OP_RTYPE:       reads_rt = is_rtype_funct(instr[5:0]) &&
                                       instr[5:0] != FN_JR && instr[5:0] != FN_JALR;
            OP_SW, OP_BEQ,
            OP_BNE:         reads_rt = 1'b1;
            default:        reads_rt = 1'b0;
        endcase
    endfunction

    function automatic logic is_jump_imm(input logic [31:0] instr);
        is_jump_imm = (instr[31:26] == OP_J) || (instr[31:26] == OP_JAL);
    endfunction

    function automatic logic is_jump_reg(input logic [31:0] instr);
        is_jump_reg = (instr[31:26] == OP_RTYPE) &&
                      (instr[5:0] == FN_JR || instr[5:0] == FN_JALR);
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/pipeline_id_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_id_ctrl_if
//  Description : Fetch <-> ID control interface. The fetch stage (master)
//                presents the fetched word, its PC+4 and the current PC; the
//                ID control block (slave) returns stall, next-PC select and
//                the jump target field.
//    if_instr [31:0] fetched instruction     if_pc4 [31:0] PC+4 of if_instr
//    pc       [31:0] current PC, bit31=kernel stall        hold PC and IF/ID
//    pcsrc    [2:0]  next-PC select          jt     [25:0] jump target field
//  Revision    : 1.0  initial release
// ============================================================================
interface pipeline_id_ctrl_if;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic [31:0] pc;
    logic        stall;
    logic [2:0]  pcsrc;
    logic [25:0] jt;

    modport master (
        output if_instr, if_pc4, pc,
        input  stall, pcsrc, jt
    );

    modport slave (
        input  if_instr, if_pc4, pc,
        output stall, pcsrc, jt
    );
endinterface : pipeline_id_ctrl_if
`default_nettype wire

// File: rtl/id_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : id_hazard_detect
//  Description : Combinational load-use hazard compare between the load in EX
//                and the source registers of the instruction held in ID.
//    ex_mem_read in  EX holds a load      ex_rt [4:0] in  load destination
//    id_instr    in  IF/ID instruction    load_use    out hazard present
//  Revision    : 1.0  initial release
// ============================================================================
module id_hazard_detect
    import mips_pkg::*;
(
    input  wire logic        ex_mem_read,
    input  wire logic [4:0]  ex_rt,
    input  wire logic [31:0] id_instr,
    output logic             load_use
);
    logic w_rs_hit;
    logic w_rt_hit;

    // $zero never creates a dependency, so a load into r0 is ignored.
    assign w_rs_hit = reads_rs(id_instr) && (id_instr[25:21] == ex_rt);
    assign w_rt_hit = reads_rt(id_instr) && (id_instr[20:16] == ex_rt);
    assign load_use = ex_mem_read && (ex_rt != 5'd0) && (w_rs_hit || w_rt_hit);
endmodule : id_hazard_detect
`default_nettype wire

// File: rtl/pipeline_id_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_id_ctrl
//  Description : IF/ID pipeline register and next-PC control. Decodes control
//                transfers in ID, detects load-use hazards and undefined
//                opcodes, and services external interrupts.
//    clk, reset (async, active-high)
//    fetch        slave side of the fetch interface (stall/pcsrc/jt out)
//    irq          level interrupt request
//    ex_mem_read, ex_rt, ex_branch, ex_alu_out0   EX-stage status
//    id_instr, id_pc4, id_valid                   IF/ID register contents
//    id_ex_flush  bubble into ID/EX              epc  saved return address
//    irq_ack      high in the cycle an IRQ is serviced
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_id_ctrl
    import mips_pkg::*;
#(
    parameter logic [2:0] IRQ_VEC_SEL = 3'd4,
    parameter logic [2:0] EXC_VEC_SEL = 3'd5
) (
    input  wire logic            clk,
    input  wire logic            reset,
    pipeline_id_ctrl_if.slave    fetch,
    input  wire logic            irq,
    input  wire logic            ex_mem_read,
    input  wire logic [4:0]      ex_rt,
    input  wire logic            ex_branch,
    input  wire logic            ex_alu_out0,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_pc4,
    output logic                 id_valid,
    output logic                 id_ex_flush,
    output logic [31:0]          epc,
    output logic                 irq_ack
);
    logic [31:0] r_id_instr;
    logic [31:0] r_id_pc4;
    logic        r_id_valid;
    logic [31:0] r_epc;
    logic        r_irq_q;
    logic        r_irq_pending;

    logic        w_load_use;
    logic        w_irq_rise;
    id_event_e   w_event;

    // Only the kernel-mode bit of the PC is relevant here.
    logic        w_unused_pc;
    assign w_unused_pc = &{1'b0, fetch.pc[30:0]};

    id_hazard_detect u_hazard (
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .id_instr    (r_id_instr),
        .load_use    (w_load_use)
    );

    assign w_irq_rise = irq && !r_irq_q;

    // Strict priority: only the first true event acts this cycle.
    always_comb begin
        w_event = EV_SEQ;
        if (ex_branch && !ex_alu_out0)
            w_event = EV_BRANCH;
        else if (w_load_use)
            w_event = EV_LOAD_USE;
        else if (r_id_valid && !is_defined(r_id_instr))
            w_event = EV_EXC;
        else if (r_irq_pending && r_id_valid && !fetch.pc[31])
            w_event = EV_IRQ;
        else if (is_jump_imm(r_id_instr) || is_jump_reg(r_id_instr))
            w_event = EV_JUMP;
    end

    always_comb begin
        fetch.stall = 1'b0;
        fetch.pcsrc = PCSRC_SEQ;
        id_ex_flush = 1'b0;
        irq_ack     = 1'b0;
        case (w_event)
            EV_BRANCH: begin
                fetch.pcsrc = PCSRC_BRANCH;
                id_ex_flush = 1'b1;
            end
            EV_LOAD_USE: begin
                fetch.stall = 1'b1;
                id_ex_flush = 1'b1;
            end
            EV_EXC: begin
                fetch.pcsrc = EXC_VEC_SEL;
                id_ex_flush = 1'b1;
            end
            EV_IRQ: begin
                fetch.pcsrc = IRQ_VEC_SEL;
                id_ex_flush = 1'b1;
                irq_ack     = 1'b1;
            end
            EV_JUMP: begin
                fetch.pcsrc = is_jump_reg(r_id_instr) ? PCSRC_REG : PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign fetch.jt = r_id_instr[25:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_id_instr    <= NOP;
            r_id_pc4      <= 32'h0;
            r_id_valid    <= 1'b0;
            r_epc         <= 32'h0;
            r_irq_q       <= 1'b0;
            r_irq_pending <= 1'b0;
        end else begin
            r_irq_q <= irq;
            // A new rising edge wins over a same-cycle service so it is not lost.
            if (w_irq_rise)
                r_irq_pending <= 1'b1;
            else if (w_event == EV_IRQ)
                r_irq_pending <= 1'b0;

            case (w_event)
                EV_LOAD_USE: ;  // IF/ID holds while the load completes
                EV_SEQ: begin
                    r_id_instr <= fetch.if_instr;
                    r_id_pc4   <= fetch.if_pc4;
                    r_id_valid <= 1'b1;
                end
                default: begin
                    // Bubble: same contents as the post-reset IF/ID
                    r_id_instr <= NOP;
                    r_id_pc4   <= 32'h0;
                    r_id_valid <= 1'b0;
                end
            endcase

            if (w_event == EV_EXC || w_event == EV_IRQ)
                r_epc <= r_id_pc4 - 32'd4;
        end
    end

    assign id_instr = r_id_instr;
    assign id_pc4   = r_id_pc4;
    assign id_valid = r_id_valid;
    assign epc      = r_epc;
endmodule : pipeline_id_ctrl
`default_nettype wire

// File: tb/tb_pipeline_id_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_id_ctrl
//  Description : Scoreboard bench for pipeline_id_ctrl: a reference model
//                computes the expected outputs of every cycle, pushes them to
//                a queue, and a monitor compares them on the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_id_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        irq = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_rt = 5'd0;
    logic        ex_branch = 1'b0;
    logic        ex_alu_out0 = 1'b1;
    logic [31:0] id_instr, id_pc4, epc;
    logic        id_valid, id_ex_flush, irq_ack;

    pipeline_id_ctrl_if fetch ();

    pipeline_id_ctrl #(.IRQ_VEC_SEL(3'd4), .EXC_VEC_SEL(3'd5)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch       (fetch),
        .irq         (irq),
        .ex_mem_read (ex_mem_read),
        .ex_rt       (ex_rt),
        .ex_branch   (ex_branch),
        .ex_alu_out0 (ex_alu_out0),
        .id_instr    (id_instr),
        .id_pc4      (id_pc4),
        .id_valid    (id_valid),
        .id_ex_flush (id_ex_flush),
        .epc         (epc),
        .irq_ack     (irq_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [2:0]  pcsrc;
        logic [25:0] jt;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        flush;
        logic [31:0] epc;
        logic        ack;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // ---------------- reference model state ----------------
    logic [31:0] m_instr = 0, m_pc4 = 0, m_epc = 0;
    bit          m_valid = 0, m_pend = 0, m_irqq = 0;

    function automatic bit m_defined(logic [31:0] w);
        logic [5:0] op, fn;
        op = w[31:26];
        fn = w[5:0];
        if (op == 0)
            return fn inside {0, 2, 3, 8, 9, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
        if (op == 1)
            return w[20:16] == 0;
        return op inside {2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 15, 35, 43};
    endfunction

    function automatic bit m_uses_rs(logic [31:0] w);
        if (!m_defined(w)) return 0;
        if (w[31:26] inside {2, 3, 15}) return 0;
        if (w[31:26] == 0 && w[5:0] inside {0, 2, 3}) return 0;
        return 1;
    endfunction

    function automatic bit m_uses_rt(logic [31:0] w);
        if (w[31:26] == 0) return m_defined(w) && !(w[5:0] inside {8, 9});
        return w[31:26] inside {4, 5, 43};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // One clock cycle: drive inputs just after the rising edge, push the
    // expected outputs for this cycle, then advance the model.
    task automatic cycle(input bit rst, input logic [31:0] instr, input logic [31:0] pc4,
                         input logic [31:0] pcv, input bit irqv, input bit mr,
                         input logic [4:0] ert, input bit br, input bit a0);
        exp_t e;
        bit taken, lu, undef, irq_ev, rise;
        @(posedge clk);
        #1;
        reset = rst; fetch.if_instr = instr; fetch.if_pc4 = pc4; fetch.pc = pcv;
        irq = irqv; ex_mem_read = mr; ex_rt = ert; ex_branch = br; ex_alu_out0 = a0;
        if (rst) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0; m_epc = 0; m_pend = 0; m_irqq = 0;
        end
        taken  = br && !a0;
        lu     = mr && ert != 0 &&
                 ((m_uses_rs(m_instr) && m_instr[25:21] == ert) ||
                  (m_uses_rt(m_instr) && m_instr[20:16] == ert));
        undef  = m_valid && !m_defined(m_instr);
        irq_ev = m_pend && m_valid && !pcv[31];
        e = '{stall: 0, pcsrc: 0, jt: m_instr[25:0], instr: m_instr, pc4: m_pc4,
              valid: m_valid, flush: 0, epc: m_epc, ack: 0};
        if (taken)       begin e.pcsrc = 1; e.flush = 1; end
        else if (lu)     begin e.stall = 1; e.flush = 1; end
        else if (undef)  begin e.pcsrc = 5; e.flush = 1; end
        else if (irq_ev) begin e.pcsrc = 4; e.flush = 1; e.ack = 1; end
        else if (m_instr[31:26] inside {2, 3}) e.pcsrc = 2;
        else if (m_instr[31:26] == 0 && m_instr[5:0] inside {8, 9}) e.pcsrc = 3;
        q.push_back(e);
        if (!rst) begin
            rise = irqv && !m_irqq;
            m_irqq = irqv;
            if (rise) m_pend = 1;
            else if (e.ack) m_pend = 0;
            if (e.pcsrc == 4 || e.pcsrc == 5) m_epc = m_pc4 - 4;
            if (!lu || taken) begin
                if (e.pcsrc == 0) begin
                    m_instr = instr; m_pc4 = pc4; m_valid = 1;
                end else begin
                    m_instr = 0; m_pc4 = 0; m_valid = 0;
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        imm = 16'($urandom);
        case ($urandom_range(0, 13))
            0:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};        // add
            1:  return {6'h00, rs, rt, rd, 5'd0, 6'h2A};        // slt
            2:  return {6'h00, 5'd0, rt, rd, 5'd3, 6'h00};      // sll
            3:  return {6'h00, rs, 15'd0, 6'h08};               // jr
            4:  return {6'h23, rs, rt, imm};                    // lw
            5:  return {6'h2B, rs, rt, imm};                    // sw
            6:  return {6'h08, rs, rt, imm};                    // addi
            7:  return {6'h04, rs, rt, imm};                    // beq
            8:  return {6'h0F, rs, rt, imm};                    // lui
            9:  return {6'h02, 26'($urandom)};                  // j
            10: return {6'h01, rs, 5'd0, imm};                  // bltz
            11: return {6'h3F, 26'($urandom)};                  // undefined
            12: return {6'h00, rs, rt, rd, 5'd0, 6'h3F};        // undefined funct
            default: return $urandom;
        endcase
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stall",    {31'd0, fetch.stall}, {31'd0, e.stall});
            chk("pcsrc",    {29'd0, fetch.pcsrc}, {29'd0, e.pcsrc});
            chk("jt",       {6'd0, fetch.jt},     {6'd0, e.jt});
            chk("id_instr", id_instr,             e.instr);
            chk("id_pc4",   id_pc4,               e.pc4);
            chk("id_valid", {31'd0, id_valid},    {31'd0, e.valid});
            chk("flush",    {31'd0, id_ex_flush}, {31'd0, e.flush});
            chk("epc",      epc,                  e.epc);
            chk("irq_ack",  {31'd0, irq_ack},     {31'd0, e.ack});
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [31:0] ADDI = 32'h21080001;
    localparam logic [31:0] KPC  = 32'h80000040;

    initial begin
        fetch.if_instr = 0; fetch.if_pc4 = 0; fetch.pc = 0;
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1);
        // load-use: lw $8 then add $8,$8,$9
        cycle(0, 32'h8C080000, 32'h04, 32'h00, 0, 0, 0, 0, 1);
        cycle(0, 32'h01094020, 32'h08, 32'h04, 0, 0, 0, 0, 1);
        cycle(0, 32'h00000000, 32'h0C, 32'h08, 0, 1, 8, 0, 1);
        cycle(0, 32'h00000000, 32'h0C, 32'h08, 0, 0, 0, 0, 1);
        // branch taken beats a simultaneous load-use
        cycle(0, 32'h01094020, 32'h10, 32'h0C, 0, 0, 0, 0, 1);
        cycle(0, ADDI,         32'h14, 32'h10, 0, 1, 8, 1, 0);
        cycle(0, ADDI,         32'h18, 32'h14, 0, 0, 0, 0, 1);
        // jal then jr $ra
        cycle(0, 32'h0C000010, 32'h24, 32'h20, 0, 0, 0, 0, 1);
        cycle(0, ADDI,         32'h28, 32'h24, 0, 0, 0, 0, 1);
        cycle(0, 32'h03E00008, 32'h2C, 32'h28, 0, 0, 0, 0, 1);
        cycle(0, ADDI,         32'h30, 32'h2C, 0, 0, 0, 0, 1);
        cycle(0, ADDI,         32'h34, 32'h30, 0, 0, 0, 0, 1);
        // user-mode IRQ with id_pc4 = 0x40
        cycle(0, ADDI,         32'h40, 32'h40, 0, 0, 0, 0, 1);
        cycle(0, ADDI,         32'h40, 32'h40, 1, 0, 0, 0, 1);
        cycle(0, ADDI,         32'h40, 32'h40, 1, 0, 0, 0, 1);
        cycle(0, ADDI,         32'h40, 32'h40, 0, 0, 0, 0, 1);
        // kernel mode holds the IRQ pending until pc[31] drops
        cycle(0, ADDI,         32'h40, KPC,    0, 0, 0, 0, 1);
        cycle(0, ADDI,         32'h40, KPC,    1, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, ADDI, 32'h40, KPC, 1, 0, 0, 0, 1);
        cycle(0, ADDI,         32'h40, 32'h40, 1, 0, 0, 0, 1);
        cycle(0, ADDI,         32'h40, 32'h40, 0, 0, 0, 0, 1);
        // undefined opcode at id_pc4 = 0x20
        cycle(0, 32'hFC000000, 32'h20, 32'h1C, 0, 0, 0, 0, 1);
        cycle(0, ADDI,         32'h24, 32'h20, 0, 0, 0, 0, 1);
        cycle(0, ADDI,         32'h28, 32'h24, 0, 0, 0, 0, 1);
        // reset while an IRQ is pending
        cycle(0, ADDI,         32'h40, KPC,    0, 0, 0, 0, 1);
        cycle(0, ADDI,         32'h40, KPC,    1, 0, 0, 0, 1);
        cycle(0, ADDI,         32'h40, KPC,    1, 0, 0, 0, 1);
        cycle(1, ADDI,         32'h40, 32'h40, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, ADDI, 32'h44, 32'h40, 0, 0, 0, 0, 1);
        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            logic [31:0] pcv;
            pcv = {($urandom_range(0, 3) == 0), 31'($urandom_range(0, 255) * 4)};
            cycle(($urandom_range(0, 99) == 0), rand_instr(), 32'($urandom_range(1, 255) * 4), pcv,
                  (($urandom_range(0, 7) == 0) ? ~irq : irq),
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 4) == 0), 1'($urandom));
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d entries left, expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipeline_id_ctrl
`default_nettype wire

// File: doc/pipeline_id_ctrl.md
Name: pipeline_id_ctrl

Overview:
- IF/ID pipeline register plus next-PC control for the 5-stage MIPS pipeline.
- Latches the fetched instruction and PC+4, decodes control transfers in ID, and detects load-use hazards and undefined opcodes.
- Handles IRQs and drives the stall/PCSrc/JT selection inputs consumed by the fetch stage.
- It is the control end of the fetch interface: the fetch stage produces PC/IF_PC, and this block decides what fetch does next.

Parameters:
- IRQ_VEC_SEL, 3'd4, PCSrc code selecting the interrupt vector 0x80000004
- EXC_VEC_SEL, 3'd5, PCSrc code selecting the exception vector 0x80000008

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- if_instr  in  32  instruction read at the current PC
- if_pc4  in  32  PC+4 of if_instr (fetch-stage IF_PC)
- pc  in  32  current PC; bit 31 = kernel mode
- irq  in  1  external interrupt request, level
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  5  destination register of the EX load
- ex_branch  in  1  instruction in EX is a conditional branch
- ex_alu_out0  in  1  branch condition from EX; 0 = taken
- stall  out  1  hold PC and IF/ID
- pcsrc  out  3  next-PC select: 0 seq, 1 branch, 2 jump, 3 register, 4 IRQ, 5 exception
- jt  out  26  jump target field of id_instr
- id_instr  out  32  IF/ID instruction register
- id_pc4  out  32  IF/ID PC+4 register
- id_valid  out  1  IF/ID holds a real instruction (not a bubble)
- id_ex_flush  out  1  insert a bubble into ID/EX this cycle
- epc  out  32  saved return address, registered
- irq_ack  out  1  one-cycle pulse when an IRQ is serviced

Behaviour:
- Reset: id_instr = 0 (nop), id_pc4 = 0, id_valid = 0, epc = 0, irq_ack = 0, irq_q = 0, irq_pending = 0. Combinational outputs resolve to stall = 0, pcsrc = 0, id_ex_flush = 0.
- pcsrc, stall, id_ex_flush and jt are combinational from the registered ID state and EX inputs, valid in the same cycle. jt = id_instr[25:0] always.
- Events, evaluated in strict priority order; only the first true event acts:
  1. Branch taken (ex_branch & ~ex_alu_out0): pcsrc = 1, stall = 0, id_ex_flush = 1. Next edge loads nop, id_valid = 0.
  2. Load-use: ex_mem_read, ex_rt != 0, and ex_rt equals id_instr rs[25:21] or rt[20:16] for an instruction that reads it. Then stall = 1, pcsrc = 0, id_ex_flush = 1. IF/ID holds.
  3. Undefined opcode in ID with id_valid: pcsrc = EXC_VEC_SEL, id_ex_flush = 1. epc <= id_pc4 - 4. Next edge loads nop.
  4. IRQ: irq_pending & id_valid & ~pc[31]. pcsrc = IRQ_VEC_SEL, id_ex_flush = 1. epc <= id_pc4 - 4, irq_ack = 1 for that cycle, irq_pending cleared. Next edge loads nop.
  5. Jump in ID: j/jal give pcsrc = 2; jr/jalr give pcsrc = 3. No flush of ID (the jump proceeds). Next edge loads nop into IF/ID (no delay slot).
  6. Otherwise: pcsrc = 0. IF/ID <= {if_instr, if_pc4}, id_valid = 1.
- IRQ capture: irq_q <= irq each cycle. A rising edge (irq & ~irq_q) sets irq_pending.
  - Set and service in the same cycle: pending stays set, serviced next eligible cycle.
  - In kernel mode (pc[31] = 1) the IRQ is held pending, not dropped.
- An exception is taken in kernel mode too. A pending IRQ is never taken on a bubble (id_valid = 0).
- Reset mid-operation clears pending IRQ and IF/ID immediately (asynchronous).
- epc changes only on event 3 or 4.

Decomposition:
- Shared package mips_pkg:
  - PCSrc codes PCSRC_SEQ..PCSRC_EXC.
  - Opcode/funct constants.
  - NOP = 32'h0.
  - Function is_defined(instr) over the supported set: R-type funct add, addu, sub, subu, and, or, xor, nor, sll, srl, sra, slt, sltu, jr, jalr; opcodes lw, sw, lui, addi, addiu, andi, slti, sltiu, beq, bne, blez, bgtz, bltz(01), j, jal.
  - Function reads_rt(instr).
- One sub-module, id_hazard_detect: combinational load-use compare.

Test Plan:
- Reset asserted mid-run with irq_pending = 1 -> id_instr = 0, id_valid = 0, epc = 0, pcsrc = 0; after reset deasserts, no irq_ack.
- if_instr = 0x8C080000 (lw $8) into EX (ex_mem_read = 1, ex_rt = 8), then ID = 0x01094020 (add $8,$8,$9) -> stall = 1, id_ex_flush = 1 for exactly one cycle, id_instr held, then proceeds.
- ex_branch = 1, ex_alu_out0 = 0 while a load-use is also present -> pcsrc = 1, stall = 0, next id_instr = 0, id_valid = 0.
- ID = 0x0C000010 (jal) -> pcsrc = 2, jt = 26'h10, next cycle id_instr = 0; ID = 0x03E00008 (jr $ra) -> pcsrc = 3.
- irq rising edge with pc = 0x00000040 and id_pc4 = 0x00000040 -> pcsrc = 4, irq_ack = 1, epc = 0x0000003C. Same with pc[31] = 1 -> held pending until pc[31] = 0.
- ID = 0xFC000000 (undefined), id_pc4 = 0x00000020 -> pcsrc = 5, epc = 0x0000001C, id_ex_flush = 1, no irq_ack.
